core_bus_arbiter: RTL and testbench

Memory-side neighbour of the pipeline core: merges the core's instruction bus (`ireq`/`iresp`) and data bus (`dreq`/`dresp`) onto one single-beat memory request channel. Keeps one transaction outstanding at a time and latches the granted request so the memory side sees stable signals. Returns responses on the originating bus. Drops responses for requests the core has withdrawn or changed, such as after a redirect or flush.

---
 rtl/core_bus_arbiter_if.sv | 78 +++++++
 rtl/core_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_core_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// Bus payload types and the core/memory-facing interface of the bus arbiter.
package core_bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned IDATA_W = 32;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned STRB_W  = 8;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic               addr_ok;
    logic               data_ok;
    logic [IDATA_W-1:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  // Latched memory request held stable for the whole transaction.
  typedef struct packed {
    logic              is_write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } mreq_t;

endpackage

// Core-side buses plus the single-beat memory channel.
interface core_bus_arbiter_if;
  import core_bus_arbiter_pkg::*;

  ibus_req_t         ireq;
  ibus_resp_t        iresp;
  dbus_req_t         dreq;
  dbus_resp_t        dresp;

  logic              mreq_valid;
  logic              mreq_is_write;
  logic [SIZE_W-1:0] mreq_size;
  logic [ADDR_W-1:0] mreq_addr;
  logic [STRB_W-1:0] mreq_strobe;
  logic [DATA_W-1:0] mreq_data;
  logic              mresp_ready;
  logic [DATA_W-1:0] mresp_data;

  // Arbiter side.
  modport slave (
    input  ireq, dreq, mresp_ready, mresp_data,
    output iresp, dresp,
    output mreq_valid, mreq_is_write, mreq_size, mreq_addr, mreq_strobe, mreq_data
  );

  // Core + memory side.
  modport master (
    output ireq, dreq, mresp_ready, mresp_data,
    input  iresp, dresp,
    input  mreq_valid, mreq_is_write, mreq_size, mreq_addr, mreq_strobe, mreq_data
  );

endinterface

// File: rtl/core_bus_arbiter.sv
// Merges the core's instruction and data buses onto one single-beat memory
// channel with one transaction in flight; responses go back to the
// originating bus only if that bus still presents the same request.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned DPRIO = 1
) (
  input  logic               clk,
  input  logic               reset,
  core_bus_arbiter_if.slave  bus
);

  localparam logic [SIZE_W-1:0] IBUS_SIZE = SIZE_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  state_e state_q, state_d;
  mreq_t  req_q, req_d;
  logic   last_d_q, last_d_d;

  logic   i_elig;
  logic   d_elig;
  logic   grant_d;
  logic   busy;
  logic   i_hit;
  logic   d_hit;

  // State, latched request and fairness bit; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      last_d_q <= last_d_d;
    end
  end

  // Grant decision: dbus by default, but fetch wins right after a dbus grant.
  always_comb begin
    i_elig = bus.ireq.valid && (bus.ireq.addr[1:0] == 2'b00);
    d_elig = bus.dreq.valid;
    if (DPRIO != 0) begin
      grant_d = d_elig && !(last_d_q && i_elig);
    end else begin
      // Plain alternation: on contention take the bus not served last.
      grant_d = d_elig && (!i_elig || !last_d_q);
    end
  end

  // Next state, request latch and last-grant tracking.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    last_d_d = last_d_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          req_d.is_write = |bus.dreq.strobe;
          req_d.size     = bus.dreq.size;
          req_d.addr     = bus.dreq.addr;
          req_d.strobe   = bus.dreq.strobe;
          req_d.data     = bus.dreq.data;
          state_d        = DBUSY;
        end else if (i_elig) begin
          req_d.is_write = 1'b0;
          req_d.size     = IBUS_SIZE;
          req_d.addr     = bus.ireq.addr;
          req_d.strobe   = '0;
          req_d.data     = '0;
          state_d        = IBUSY;
        end
      end
      IBUSY: begin
        if (bus.mresp_ready) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end
      end
      DBUSY: begin
        if (bus.mresp_ready) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory request straight from the latched copy; zero while idle.
  always_comb begin
    busy              = (state_q != IDLE);
    bus.mreq_valid    = busy;
    bus.mreq_is_write = busy && req_q.is_write;
    bus.mreq_size     = busy ? req_q.size   : '0;
    bus.mreq_addr     = busy ? req_q.addr   : '0;
    bus.mreq_strobe   = busy ? req_q.strobe : '0;
    bus.mreq_data     = busy ? req_q.data   : '0;
  end

  // Completion matching: answer only if the core still asks for the same thing.
  always_comb begin
    i_hit = (state_q == IBUSY) && bus.mresp_ready && bus.ireq.valid &&
            (bus.ireq.addr == req_q.addr);
    d_hit = (state_q == DBUSY) && bus.mresp_ready && bus.dreq.valid &&
            (bus.dreq.addr == req_q.addr) && (bus.dreq.size == req_q.size) &&
            (bus.dreq.strobe == req_q.strobe);

    bus.iresp = '0;
    if (i_hit) begin
      bus.iresp.addr_ok = 1'b1;
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = req_q.addr[2] ? bus.mresp_data[63:32] : bus.mresp_data[31:0];
    end

    bus.dresp = '0;
    if (d_hit) begin
      bus.dresp.addr_ok = 1'b1;
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = bus.mresp_data;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter with a transaction-level reference model.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic clk;
  logic reset;

  core_bus_arbiter_if bus ();

  core_bus_arbiter #(.DPRIO(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference model: who owns the memory channel (0 none, 1 fetch, 2 data).
  int          m_src    = 0;
  bit          m_last_d = 1'b0;
  logic        m_wr     = 1'b0;
  logic [63:0] m_addr   = '0;
  logic [2:0]  m_size   = '0;
  logic [7:0]  m_strobe = '0;
  logic [63:0] m_data   = '0;
  int          grant_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Model advance at each clock edge.
  always @(posedge clk) begin
    bit iv, dv;
    int pick;
    if (!reset) begin
      m_src = 0; m_last_d = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_size = '0; m_strobe = '0; m_data = '0;
    end else if (m_src == 0) begin
      iv = bus.ireq.valid && (bus.ireq.addr % 4 == 0);
      dv = bus.dreq.valid;
      pick = 0;
      if (dv && iv) pick = m_last_d ? 1 : 2;
      else if (dv)  pick = 2;
      else if (iv)  pick = 1;
      if (pick == 2) begin
        m_wr = (bus.dreq.strobe != 0); m_addr = bus.dreq.addr; m_size = bus.dreq.size;
        m_strobe = bus.dreq.strobe; m_data = bus.dreq.data;
      end else if (pick == 1) begin
        m_wr = 1'b0; m_addr = bus.ireq.addr; m_size = 3'd2; m_strobe = 8'd0; m_data = 64'd0;
      end
      if (pick != 0) begin
        m_src = pick;
        grant_log.push_back(pick);
      end
    end else if (bus.mresp_ready) begin
      m_last_d = (m_src == 2);
      m_src = 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    bit          busy, i_ok, d_ok;
    logic [63:0] half;
    if (chk_en) begin
      busy = (m_src != 0);
      chk("mreq_valid",    bus.mreq_valid,    busy);
      chk("mreq_is_write", bus.mreq_is_write, busy ? m_wr     : 1'b0);
      chk("mreq_size",     bus.mreq_size,     busy ? m_size   : 3'd0);
      chk("mreq_addr",     bus.mreq_addr,     busy ? m_addr   : 64'd0);
      chk("mreq_strobe",   bus.mreq_strobe,   busy ? m_strobe : 8'd0);
      chk("mreq_data",     bus.mreq_data,     busy ? m_data   : 64'd0);
      i_ok = (m_src == 1) && bus.mresp_ready && bus.ireq.valid && (bus.ireq.addr == m_addr);
      d_ok = (m_src == 2) && bus.mresp_ready && bus.dreq.valid && (bus.dreq.addr == m_addr) &&
             (bus.dreq.size == m_size) && (bus.dreq.strobe == m_strobe);
      chk("iresp_addr_ok", bus.iresp.addr_ok, i_ok);
      chk("iresp_data_ok", bus.iresp.data_ok, i_ok);
      chk("dresp_addr_ok", bus.dresp.addr_ok, d_ok);
      chk("dresp_data_ok", bus.dresp.data_ok, d_ok);
      half = (bus.mresp_data >> (m_addr[2] * 32)) & 64'hFFFF_FFFF;
      if (i_ok)       chk("iresp_data", 64'(bus.iresp.data), half);
      else if (!busy) chk("iresp_data_idle", 64'(bus.iresp.data), 64'd0);
      if (d_ok)       chk("dresp_data", bus.dresp.data, bus.mresp_data);
      else if (!busy) chk("dresp_data_idle", bus.dresp.data, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [63:0] a);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mreq_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("grant_timeout", 64'd0, 64'd1);
    a = bus.mreq_addr;
  endtask

  task automatic start_resp(input logic [63:0] d);
    tick();
    bus.mresp_ready = 1'b1;
    bus.mresp_data  = d;
    @(negedge clk);
  endtask

  task automatic end_resp();
    tick();
    bus.mresp_ready = 1'b0;
    bus.mresp_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] obs[4];
    int          log_start;
    logic [63:0] exp_addr[4];

    reset = 1'b0;
    bus.ireq = '0;
    bus.dreq = '0;
    bus.mresp_ready = 1'b0;
    bus.mresp_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_mreq_valid", bus.mreq_valid, 1'b0);
    chk("reset_dresp_ok", bus.dresp.data_ok, 1'b0);

    // Store.
    tick();
    bus.dreq = '{valid: 1'b1, addr: 64'h8000_1000, size: 3'd3, strobe: 8'hFF,
                 data: 64'hDEAD_BEEF_0000_0001};
    wait_grant(a);
    chk("st_addr", a, 64'h8000_1000);
    chk("st_wr", bus.mreq_is_write, 1'b1);
    chk("st_size", bus.mreq_size, 3'd3);
    chk("st_strobe", bus.mreq_strobe, 8'hFF);
    chk("st_data", bus.mreq_data, 64'hDEAD_BEEF_0000_0001);
    chk("st_early_ok", bus.dresp.data_ok, 1'b0);
    start_resp(64'h0);
    chk("st_ok", bus.dresp.data_ok, 1'b1);
    end_resp();
    bus.dreq.valid = 1'b0;
    @(negedge clk);
    chk("st_ok_drop", bus.dresp.data_ok, 1'b0);
    chk("st_idle", bus.mreq_valid, 1'b0);

    // Single fetch, upper word.
    tick();
    bus.ireq = '{valid: 1'b1, addr: 64'h8000_0004};
    wait_grant(a);
    chk("if_addr", a, 64'h8000_0004);
    chk("if_size", bus.mreq_size, 3'd2);
    chk("if_strobe", bus.mreq_strobe, 8'd0);
    chk("if_wr", bus.mreq_is_write, 1'b0);
    repeat (2) @(posedge clk);
    start_resp(64'h1111_2222_3333_4444);
    chk("if_ok", bus.iresp.data_ok, 1'b1);
    chk("if_aok", bus.iresp.addr_ok, 1'b1);
    chk("if_data", 64'(bus.iresp.data), 64'h1111_2222);
    end_resp();
    bus.ireq.valid = 1'b0;

    // Contention: both valid; last grant was fetch, so D first.
    tick();
    bus.ireq = '{valid: 1'b1, addr: 64'h8000_0000};
    bus.dreq = '{valid: 1'b1, addr: 64'h8000_2000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    log_start = grant_log.size();
    exp_addr[0] = 64'h8000_2000; exp_addr[1] = 64'h8000_0000;
    exp_addr[2] = 64'h8000_2000; exp_addr[3] = 64'h8000_0000;
    for (int g = 0; g < 4; g++) begin
      wait_grant(obs[g]);
      start_resp(64'hA5A5_0000_0000_0000 + 64'(g));
      end_resp();
    end
    for (int g = 0; g < 4; g++) begin
      chk("order_dut", obs[g], exp_addr[g]);
      chk("order_model", 64'(grant_log[log_start + g]), (g % 2 == 0) ? 64'd2 : 64'd1);
    end

    // Fifth goes to D, sixth to I; fetch address changes mid-flight.
    wait_grant(a);
    chk("c5_addr", a, 64'h8000_2000);
    start_resp(64'h5);
    end_resp();
    wait_grant(a);
    chk("c6_addr", a, 64'h8000_0000);
    tick();
    bus.ireq.addr  = 64'h8000_0100;
    bus.dreq.valid = 1'b0;
    start_resp(64'h6);
    chk("redirect_no_ok", bus.iresp.data_ok, 1'b0);
    chk("redirect_stable", bus.mreq_addr, 64'h8000_0000);
    end_resp();
    wait_grant(a);
    chk("redirect_next", a, 64'h8000_0100);
    start_resp(64'h1111_2222_3333_4444);
    chk("lo_ok", bus.iresp.data_ok, 1'b1);
    chk("lo_data", 64'(bus.iresp.data), 64'h3333_4444);
    end_resp();
    bus.ireq.valid = 1'b0;

    // Withdrawal of a dbus read.
    tick();
    bus.dreq = '{valid: 1'b1, addr: 64'h8000_3000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    wait_grant(a);
    chk("wd_addr", a, 64'h8000_3000);
    tick();
    bus.dreq.valid = 1'b0;
    bus.ireq = '{valid: 1'b1, addr: 64'h8000_0200};
    start_resp(64'h77);
    chk("wd_no_ok", bus.dresp.data_ok, 1'b0);
    end_resp();
    @(negedge clk);
    chk("wd_dead", bus.mreq_valid, 1'b0);
    @(negedge clk);
    chk("wd_next_valid", bus.mreq_valid, 1'b1);
    chk("wd_next_addr", bus.mreq_addr, 64'h8000_0200);
    start_resp(64'h88);
    end_resp();
    bus.ireq.valid = 1'b0;

    // Stray completion while idle.
    tick();
    bus.mresp_ready = 1'b1;
    bus.mresp_data  = 64'h99;
    @(negedge clk);
    chk("idle_ready_i", bus.iresp.data_ok, 1'b0);
    chk("idle_ready_v", bus.mreq_valid, 1'b0);
    tick();
    bus.mresp_ready = 1'b0;

    // Reset during a busy fetch.
    tick();
    bus.ireq = '{valid: 1'b1, addr: 64'h8000_0400};
    wait_grant(a);
    chk("rst_grant", a, 64'h8000_0400);
    tick();
    reset = 1'b0;
    bus.ireq.valid = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.mreq_valid, 1'b0);
    chk("rst_addr", bus.mreq_addr, 64'd0);
    tick();
    bus.mresp_ready = 1'b1;
    bus.mresp_data  = 64'hABCD;
    @(negedge clk);
    chk("rst_stale_i", bus.iresp.data_ok, 1'b0);
    chk("rst_stale_d", bus.dresp.data_ok, 1'b0);
    tick();
    bus.mresp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
